// File: rtl/config_reg_loader.sv
// SPI mode-0 write front end for the 4x16b configuration bank, oversampled on clk_i.
// Define CFG_LOADER_READBACK_EN to return register contents on MISO for read frames.
module config_reg_loader #(
    parameter int WR_PULSE = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        reg_wr_o,
    output logic [1:0]  reg_adr_o,
    output logic [15:0] reg_dat_o,
    input  logic [15:0] reg0_i,
    input  logic [15:0] reg1_i,
    input  logic [15:0] reg2_i,
    input  logic [15:0] reg3_i,
    output logic        busy_o,
    output logic        frame_err_o
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [2:0] SYNC_INIT   = 3'b010;  // {mosi, cs_n, sclk}
    localparam logic [3:0] STROBE_LAST = 4'(WR_PULSE - 1);
    localparam logic [4:0] BIT_FULL    = 5'd19;
    localparam logic [4:0] BIT_SAT     = 5'd20;

    logic [2:0] pin_raw;
    logic [2:0] sync_lvl;
    logic [2:0] sync_dly;

    assign pin_raw = {spi_mosi_i, spi_cs_n_i, spi_sclk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic lvl_reg;
            logic dly_reg;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    meta_reg <= SYNC_INIT[gi];
                    lvl_reg  <= SYNC_INIT[gi];
                    dly_reg  <= SYNC_INIT[gi];
                end else begin
                    meta_reg <= pin_raw[gi];
                    lvl_reg  <= meta_reg;
                    dly_reg  <= lvl_reg;
                end
            end
            assign sync_lvl[gi] = lvl_reg;
            assign sync_dly[gi] = dly_reg;
        end
    endgenerate

    logic sclk_rise_reg, sclk_fall_reg, cs_fall_reg, cs_rise_reg;
    logic mosi_bit;

    // Edge pulses are registered, so sync_dly carries MOSI/CS levels aligned with them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_rise_reg <= 1'b0;
            sclk_fall_reg <= 1'b0;
            cs_fall_reg   <= 1'b0;
            cs_rise_reg   <= 1'b0;
        end else begin
            sclk_rise_reg <= sync_lvl[0] & ~sync_dly[0];
            sclk_fall_reg <= ~sync_lvl[0] & sync_dly[0];
            cs_fall_reg   <= ~sync_lvl[1] & sync_dly[1];
            cs_rise_reg   <= sync_lvl[1] & ~sync_dly[1];
        end
    end

    assign mosi_bit = sync_dly[2];

    logic [1:0]  settle_cnt_reg;
    logic        armed_reg;
    logic        frame_active_reg;
    logic [4:0]  bit_cnt_reg;
    logic [18:0] shift_reg;
    logic        frame_err_reg;
    logic [1:0]  reg_adr_reg;
    logic [15:0] reg_dat_reg;
    logic        reg_wr_reg;
    logic        busy_reg;
    state_t      state_reg, state_next;
    logic [3:0]  str_cnt_reg, str_cnt_next;

    logic close_evt, frame_ok, wr_req, wr_accept, err_evt;

    assign close_evt = cs_rise_reg && frame_active_reg;
    assign frame_ok  = (bit_cnt_reg == BIT_FULL);
    assign wr_req    = close_evt && frame_ok && shift_reg[18];
    assign wr_accept = wr_req && (state_reg == IDLE);
    assign err_evt   = close_evt && (!frame_ok || (wr_req && state_reg != IDLE));

    // Arming waits until the sync chain holds real pin samples and CS has been seen high,
    // so a CS already low at reset release never opens a frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            settle_cnt_reg   <= 2'd0;
            armed_reg        <= 1'b0;
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= 5'd0;
            shift_reg        <= 19'd0;
            frame_err_reg    <= 1'b0;
            reg_adr_reg      <= 2'd0;
            reg_dat_reg      <= 16'd0;
        end else begin
            frame_err_reg <= err_evt;
            if (settle_cnt_reg != 2'd3) begin
                settle_cnt_reg <= settle_cnt_reg + 2'd1;
            end else if (sync_dly[1]) begin
                armed_reg <= 1'b1;
            end
            if (cs_fall_reg && armed_reg) begin
                frame_active_reg <= 1'b1;
                bit_cnt_reg      <= 5'd0;
                shift_reg        <= 19'd0;
            end else if (cs_rise_reg) begin
                frame_active_reg <= 1'b0;
            end else if (sclk_rise_reg && frame_active_reg) begin
                shift_reg <= {shift_reg[17:0], mosi_bit};
                if (bit_cnt_reg != BIT_SAT) begin
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end
            end
            if (wr_accept) begin
                reg_adr_reg <= shift_reg[17:16];
                reg_dat_reg <= shift_reg[15:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        str_cnt_next = 4'd0;
        case (state_reg)
            IDLE:   if (wr_accept) state_next = SETUP;
            SETUP:  state_next = STROBE;
            STROBE: begin
                if (str_cnt_reg == STROBE_LAST) begin
                    state_next = HOLD;
                end else begin
                    str_cnt_next = str_cnt_reg + 4'd1;
                end
            end
            HOLD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe and busy are registered from the next state so they are glitch-free flop outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            str_cnt_reg <= 4'd0;
            reg_wr_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            str_cnt_reg <= str_cnt_next;
            reg_wr_reg  <= (state_next == STROBE);
            busy_reg    <= (state_next != IDLE);
        end
    end

    assign reg_wr_o    = reg_wr_reg;
    assign reg_adr_o   = reg_adr_reg;
    assign reg_dat_o   = reg_dat_reg;
    assign busy_o      = busy_reg;
    assign frame_err_o = frame_err_reg;

`ifdef CFG_LOADER_READBACK_EN
    logic [15:0] shadow_reg;
    logic        rd_active_reg;
    logic        miso_reg;
    logic [15:0] reg_sel;
    logic [1:0]  rd_adr;
    logic        rd_load;

    // Third rising edge: shift_reg holds {rw, adr[1]} and mosi_bit is adr[0].
    assign rd_adr  = {shift_reg[0], mosi_bit};
    assign rd_load = sclk_rise_reg && frame_active_reg && (bit_cnt_reg == 5'd2) && !shift_reg[1];

    always_comb begin
        reg_sel = reg0_i;
        case (rd_adr)
            2'd1:    reg_sel = reg1_i;
            2'd2:    reg_sel = reg2_i;
            2'd3:    reg_sel = reg3_i;
            default: reg_sel = reg0_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shadow_reg    <= 16'd0;
            rd_active_reg <= 1'b0;
            miso_reg      <= 1'b0;
        end else if (!frame_active_reg || cs_rise_reg) begin
            rd_active_reg <= 1'b0;
            miso_reg      <= 1'b0;
        end else if (rd_load) begin
            shadow_reg    <= reg_sel;
            rd_active_reg <= 1'b1;
        end else if (sclk_fall_reg && rd_active_reg) begin
            miso_reg   <= shadow_reg[15];
            shadow_reg <= {shadow_reg[14:0], 1'b0};
        end
    end

    assign spi_miso_o = miso_reg;
`else
    logic unused_readback;
    assign unused_readback = ^{reg0_i, reg1_i, reg2_i, reg3_i, sclk_fall_reg};
    assign spi_miso_o      = 1'b0;
`endif

endmodule
